// File: rtl/decryption_demux_pkg.sv
// Shared constants and types for the decryption demultiplexer.
// Channel select codes, FSM state type and default data widths.
package decryption_demux_pkg;

  localparam int MST_DWIDTH_DEF = 32;
  localparam int SYS_DWIDTH_DEF = 8;
  localparam int CHARS_PER_WORD = 4;

  localparam logic [1:0] CAESAR  = 2'd0;
  localparam logic [1:0] SCYTALE = 2'd1;
  localparam logic [1:0] ZIGZAG  = 2'd2;
  localparam logic [1:0] INVALID = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO buffering {word, select} entries ahead of the demux FSM.
// Pushes while full and pops while empty are ignored.
module demux_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decryption_demux.sv
// Splits 4-character master words into per-channel character strobes.
// Define DEMUX_DROP_CNT_EN to add drop_cnt_o, a saturating count of select==3 words.
module decryption_demux
  import decryption_demux_pkg::*;
#(
  parameter int MST_DWIDTH = MST_DWIDTH_DEF,
  parameter int SYS_DWIDTH = SYS_DWIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            select,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            busy_i,
  output logic [SYS_DWIDTH-1:0] data0_o,
  output logic [SYS_DWIDTH-1:0] data1_o,
  output logic [SYS_DWIDTH-1:0] data2_o,
  output logic                  valid0_o,
  output logic                  valid1_o,
  output logic                  valid2_o
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt_o
`endif
);

  localparam int FW = MST_DWIDTH + 2;

  logic [MST_DWIDTH-1:0] head_word;
  logic [1:0]            head_sel;
  logic                  empty;
  logic                  full;
  logic                  pop;

  state_t                state;
  logic [1:0]            idx;
  logic [MST_DWIDTH-1:0] word_q;
  logic [1:0]            sel_q;

  logic                  emit;
  logic [1:0]            emit_ch;
  logic [SYS_DWIDTH-1:0] emit_char;
  logic [3:0]            busy_x;

  // ready also forced high during reset so upstream never stalls on stale occupancy
  assign ready_o = !full || !rst_n;
  assign pop     = (state == IDLE) && !empty;
  assign busy_x  = {1'b1, busy_i};

  demux_fifo #(.WIDTH(FW), .DEPTH(2)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (valid_i && ready_o),
    .push_data ({data_i, select}),
    .pop       (pop),
    .head      ({head_word, head_sel}),
    .empty     (empty),
    .full      (full)
  );

  function automatic logic [SYS_DWIDTH-1:0] char_at(input logic [MST_DWIDTH-1:0] w,
                                                    input logic [1:0] k);
    return w[MST_DWIDTH - 1 - int'(k) * SYS_DWIDTH -: SYS_DWIDTH];
  endfunction

  // Character 0 leaves straight from the FIFO head so an idle channel sees it at N+2.
  always_comb begin
    emit      = 1'b0;
    emit_ch   = head_sel;
    emit_char = char_at(head_word, 2'd0);
    if (state == IDLE) begin
      emit = !empty && (head_sel != INVALID) && !busy_x[head_sel];
    end else begin
      emit_ch   = sel_q;
      emit_char = char_at(word_q, idx);
      emit      = !busy_x[sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 2'd0;
      word_q   <= '0;
      sel_q    <= CAESAR;
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
    end else begin
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
      if (emit) begin
        case (emit_ch)
          CAESAR:  begin valid0_o <= 1'b1; data0_o <= emit_char; end
          SCYTALE: begin valid1_o <= 1'b1; data1_o <= emit_char; end
          ZIGZAG:  begin valid2_o <= 1'b1; data2_o <= emit_char; end
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            word_q <= head_word;
            sel_q  <= head_sel;
            if (head_sel != INVALID) begin
              state <= SEND;
              idx   <= emit ? 2'd1 : 2'd0;
            end
          end
        end
        SEND: begin
          if (emit) begin
            if (idx == 2'd3) begin
              state <= IDLE;
              idx   <= 2'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_cnt_o <= 8'd0;
    else if (pop && (head_sel == INVALID) && (drop_cnt_o != 8'hFF))
      drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_decryption_demux.sv
// Directed self-checking bench for decryption_demux.
// Build with DEMUX_DROP_CNT_EN to also check the drop counter.
module tb_decryption_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  select;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  busy_i;
  logic [7:0]  data0_o, data1_o, data2_o;
  logic        valid0_o, valid1_o, valid2_o;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]  drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  decryption_demux #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .select   (select),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .busy_i   (busy_i),
    .data0_o  (data0_o),
    .data1_o  (data1_o),
    .data2_o  (data2_o),
    .valid0_o (valid0_o),
    .valid1_o (valid1_o),
    .valid2_o (valid2_o)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    busy_i  = 3'b000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] w [3];
    int p;
    logic acc;
    w = '{32'h10203040, 32'h50607080, 32'h90A0B0C0};
    rst_n = 1'b0; valid_i = 1'b1; select = 2'd0; data_i = 32'h12345678; busy_i = 3'b000;
    tick(); tick();
    checks++;
    if ({valid0_o, valid1_o, valid2_o} !== 3'b000)
      begin errors++; $display("FAIL reset_valid got=%b want=000", {valid0_o, valid1_o, valid2_o}); end
    checks++;
    if ({data0_o, data1_o, data2_o} !== 24'h0)
      begin errors++; $display("FAIL reset_data got=%h want=000000", {data0_o, data1_o, data2_o}); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    // Fill the FIFO behind a stalled channel, then reset while full.
    rst_n = 1'b1; valid_i = 1'b0; busy_i = 3'b001;
    p = 0;
    for (int c = 0; c < 10 && p < 3; c++) begin
      valid_i = 1'b1; data_i = w[p];
      acc = ready_o;
      tick();
      if (acc) p++;
    end
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", ready_o); end
    rst_n = 1'b0; valid_i = 1'b1; data_i = 32'hEEEEEEEE;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_during_reset got=%b want=1", ready_o); end
    tick();
    rst_n = 1'b1; valid_i = 1'b0; busy_i = 3'b000;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({valid0_o, valid1_o, valid2_o, ready_o} !== 4'b0001)
        begin errors++; $display("FAIL reset_flush cyc=%0d got=%b want=0001", c, {valid0_o, valid1_o, valid2_o, ready_o}); end
    end
  endtask

  task automatic test_caesar;
    logic [7:0] exp [4];
    exp = '{8'h41, 8'h42, 8'h43, 8'h44};
    apply_reset();
    select = 2'd0; data_i = 32'h41424344; valid_i = 1'b1; busy_i = 3'b000;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid0_o !== 1'b0) begin errors++; $display("FAIL caesar_n1 got=%b want=0", valid0_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({valid0_o, data0_o} !== {1'b1, exp[k]})
        begin errors++; $display("FAIL caesar_char%0d got=%b/%h want=1/%h", k, valid0_o, data0_o, exp[k]); end
      checks++;
      if ({valid1_o, valid2_o} !== 2'b00)
        begin errors++; $display("FAIL caesar_other%0d got=%b want=00", k, {valid1_o, valid2_o}); end
    end
    tick();
    checks++;
    if (valid0_o !== 1'b0) begin errors++; $display("FAIL caesar_tail got=%b want=0", valid0_o); end
  endtask

  task automatic test_busy;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    select = 2'd1; data_i = 32'h11223344; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; busy_i = 3'b111;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({valid0_o, valid1_o, valid2_o} !== 3'b000)
        begin errors++; $display("FAIL busy_hold%0d got=%b want=000", c, {valid0_o, valid1_o, valid2_o}); end
      tick();
    end
    // Other channels stay busy to show their busy bits are ignored.
    busy_i = 3'b101;
    checks++;
    if (valid1_o !== 1'b0) begin errors++; $display("FAIL busy_release got=%b want=0", valid1_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({valid0_o, valid1_o, valid2_o, data1_o} !== {3'b010, exp[k]})
        begin errors++; $display("FAIL busy_char%0d got=%b/%h want=010/%h", k, {valid0_o, valid1_o, valid2_o}, data1_o, exp[k]); end
    end
    tick();
    checks++;
    if (valid1_o !== 1'b0) begin errors++; $display("FAIL busy_tail got=%b want=0", valid1_o); end
    busy_i = 3'b000;
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [3];
    logic [7:0]  exp [12];
    int p, k;
    logic acc;
    w   = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4,
            8'hC1, 8'hC2, 8'hC3, 8'hC4};
    apply_reset();
    select = 2'd2;
    p = 0; k = 0;
    for (int c = 0; c < 40; c++) begin
      valid_i = (p < 3);
      data_i  = w[(p < 3) ? p : 0];
      acc     = valid_i && ready_o;
      tick();
      if (acc) begin
        p++;
        if (p == 3) begin
          checks++;
          if (ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got=%b want=0", ready_o); end
        end
      end
      if (valid2_o) begin
        checks++;
        if (k >= 12 || data2_o !== exp[(k < 12) ? k : 0])
          begin errors++; $display("FAIL b2b_char%0d got=%h want=%h", k, data2_o, exp[(k < 12) ? k : 0]); end
        k++;
      end
      checks++;
      if ({valid0_o, valid1_o} !== 2'b00)
        begin errors++; $display("FAIL b2b_other cyc=%0d got=%b want=00", c, {valid0_o, valid1_o}); end
    end
    valid_i = 1'b0;
    checks++;
    if (k !== 12) begin errors++; $display("FAIL b2b_count got=%0d want=12", k); end
    checks++;
    if (p !== 3) begin errors++; $display("FAIL b2b_accepted got=%0d want=3", p); end
  endtask

  task automatic test_drop;
    logic [31:0] w [2];
    logic [1:0]  s [2];
    logic [7:0]  exp [4];
    int p, k;
    logic acc;
    w   = '{32'hDEADBEEF, 32'h01020304};
    s   = '{2'd3, 2'd0};
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    apply_reset();
    p = 0; k = 0;
    for (int c = 0; c < 15; c++) begin
      valid_i = (p < 2);
      data_i  = w[(p < 2) ? p : 0];
      select  = s[(p < 2) ? p : 0];
      acc     = valid_i && ready_o;
      tick();
      if (acc) p++;
      if (valid0_o) begin
        checks++;
        if (k >= 4 || data0_o !== exp[(k < 4) ? k : 0])
          begin errors++; $display("FAIL drop_char%0d got=%h want=%h", k, data0_o, exp[(k < 4) ? k : 0]); end
        k++;
      end
      checks++;
      if ({valid1_o, valid2_o} !== 2'b00)
        begin errors++; $display("FAIL drop_other cyc=%0d got=%b want=00", c, {valid1_o, valid2_o}); end
    end
    valid_i = 1'b0;
    checks++;
    if (k !== 4) begin errors++; $display("FAIL drop_count got=%0d want=4", k); end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt_o !== 8'd1) begin errors++; $display("FAIL drop_cnt got=%0d want=1", drop_cnt_o); end
`endif
  endtask

  task automatic test_mid_reset;
    apply_reset();
    select = 2'd0; data_i = 32'hAABBCCDD; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    checks++;
    if ({valid0_o, data0_o} !== {1'b1, 8'hAA})
      begin errors++; $display("FAIL midrst_c0 got=%b/%h want=1/aa", valid0_o, data0_o); end
    tick();
    checks++;
    if ({valid0_o, data0_o} !== {1'b1, 8'hBB})
      begin errors++; $display("FAIL midrst_c1 got=%b/%h want=1/bb", valid0_o, data0_o); end
    rst_n = 1'b0; valid_i = 1'b1; data_i = 32'h55667788;
    tick();
    rst_n = 1'b1; valid_i = 1'b0;
    checks++;
    if ({valid0_o, valid1_o, valid2_o, data0_o} !== {3'b000, 8'h00})
      begin errors++; $display("FAIL midrst_clear got=%b/%h want=000/00", {valid0_o, valid1_o, valid2_o}, data0_o); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", ready_o); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({valid0_o, valid1_o, valid2_o} !== 3'b000)
        begin errors++; $display("FAIL midrst_quiet cyc=%0d got=%b want=000", c, {valid0_o, valid1_o, valid2_o}); end
    end
  endtask

  task automatic test_drop_saturate;
    int p;
    int stray;
    logic acc;
    apply_reset();
    select = 2'd3;
    p = 0; stray = 0;
    for (int c = 0; c < 600 && p < 260; c++) begin
      valid_i = 1'b1;
      data_i  = 32'hF0000000 | p;
      acc     = ready_o;
      tick();
      if (acc) p++;
      if (valid0_o || valid1_o || valid2_o) stray++;
    end
    valid_i = 1'b0;
    tick(); tick();
    checks++;
    if (p !== 260) begin errors++; $display("FAIL sat_accepted got=%0d want=260", p); end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL sat_stray got=%0d want=0", stray); end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_drop_cnt got=%0d want=255", drop_cnt_o); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; select = 2'd0; data_i = '0; valid_i = 1'b0; busy_i = 3'b000;
    #1;
    test_reset();
    test_caesar();
    test_busy();
    test_back_to_back();
    test_drop();
    test_mid_reset();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
